// File: rtl/rsa_modexp_core.sv
// Modular exponentiation a^e mod n (right-to-left binary method) using bit-serial
// Montgomery multiply and square datapaths that run side by side.
module rsa_modexp_core #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_val,
    output logic             o_rdy,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_e,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_val,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, CHECK, PRE, LOOP, OUT} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, e_q, n_q;
    logic [WIDTH-1:0] acc, t;
    logic [WIDTH+1:0] m_mul, m_sqr;
    logic [CW-1:0]    cnt, bit_idx, k;
    logic [WIDTH-1:0] result_q;
    logic             err_q;

    logic             n_bad, cnt_last, last_pass, e_bit;
    logic [WIDTH-1:0] mul_done, sqr_done, acc_nx;

    function automatic logic [CW-1:0] bit_len(input logic [WIDTH-1:0] v);
        logic [CW-1:0] len;
        len = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (v[b]) len = CW'(b + 1);
        end
        return len;
    endfunction

    // One bit-serial Montgomery step: add y when the scanned bit is set, make even, halve.
    function automatic logic [WIDTH+1:0] mont_step(input logic [WIDTH+1:0] m, input logic xb,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] s;
        s = m + (xb ? {2'b00, y} : '0);
        if (s[0]) s = s + {2'b00, n};
        return s >> 1;
    endfunction

    function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH+1:0] m,
                                                  input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] d;
        d = (m >= {2'b00, n}) ? m - {2'b00, n} : m;
        return d[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] dbl_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] n);
        logic [WIDTH:0] d;
        d = {x, 1'b0};
        if (d >= {1'b0, n}) d = d - {1'b0, n};
        return d[WIDTH-1:0];
    endfunction

    assign n_bad     = !n_q[0] || (n_q == WIDTH'(1));
    assign cnt_last  = (cnt == CW'(WIDTH));
    assign last_pass = (bit_idx == k - CW'(1));
    assign e_bit     = e_q[bit_idx[IW-1:0]];
    assign mul_done  = cond_sub(m_mul, n_q);
    assign sqr_done  = cond_sub(m_sqr, n_q);
    assign acc_nx    = e_bit ? mul_done : acc;

    assign o_rdy    = (state == IDLE);
    assign o_val    = (state == OUT);
    assign o_result = result_q;
    assign o_err    = err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_val) state_nx = CHECK;
            CHECK:   state_nx = n_bad ? OUT : PRE;
            PRE:     if (cnt_last) state_nx = (k == '0) ? OUT : LOOP;
            LOOP:    if (cnt_last && last_pass) state_nx = OUT;
            OUT:     if (i_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            acc      <= '0;
            t        <= '0;
            m_mul    <= '0;
            m_sqr    <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            k        <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_val) begin
                        a_q <= i_a;
                        e_q <= i_e;
                        n_q <= i_n;
                        k   <= bit_len(i_e);
                        cnt <= '0;
                    end
                end
                CHECK: begin
                    acc <= WIDTH'(1);
                    cnt <= '0;
                    if (n_bad) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end else begin
                        err_q    <= 1'b0;
                    end
                end
                // t = a*R mod n by WIDTH modular doublings
                PRE: begin
                    t <= (cnt == '0) ? a_q : dbl_mod(t, n_q);
                    if (cnt_last) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        m_mul    <= '0;
                        m_sqr    <= '0;
                        result_q <= acc;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // acc stays in the normal domain, t in the Montgomery domain
                LOOP: begin
                    if (!cnt_last) begin
                        m_mul <= mont_step(m_mul, acc[cnt[IW-1:0]], t, n_q);
                        m_sqr <= mont_step(m_sqr, t[cnt[IW-1:0]], t, n_q);
                        cnt   <= cnt + CW'(1);
                    end else begin
                        acc      <= acc_nx;
                        t        <= sqr_done;
                        m_mul    <= '0;
                        m_sqr    <= '0;
                        cnt      <= '0;
                        bit_idx  <= bit_idx + CW'(1);
                        result_q <= acc_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
